// File: rtl/snoop_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : snoop_arbiter_pkg                                               |
// | Purpose  : Shared state encoding and width helper for the snoop arbiter.   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package snoop_arbiter_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        OFFER = 2'd1,
        FILL  = 2'd2
    } arb_state_t;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/snoop_arbiter_rr_picker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : snoop_arbiter_rr_picker                                         |
// | Purpose  : Combinational round-robin priority encoder, first after rr_last.|
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module snoop_arbiter_rr_picker
    import snoop_arbiter_pkg::*;
#(
    parameter int N_CORES   = 4,
    parameter int SEL_WIDTH = clog2(N_CORES)
) (
    input  logic [N_CORES-1:0]   req,
    input  logic [SEL_WIDTH-1:0] rr_last,
    input  logic [N_CORES-1:0]   exclude,
    output logic [SEL_WIDTH-1:0] cand,
    output logic                 cand_valid
);

    logic [N_CORES-1:0]   w_eligible;
    logic [SEL_WIDTH-1:0] w_idx;

    assign w_eligible = req & ~exclude;

    // Walk from the farthest rotation back to the nearest so the nearest hit wins.
    always_comb begin
        cand       = '0;
        cand_valid = 1'b0;
        w_idx      = '0;
        for (int k = N_CORES; k >= 1; k--) begin
            w_idx = SEL_WIDTH'((int'(rr_last) + k) % N_CORES);
            if (w_eligible[w_idx]) begin
                cand       = w_idx;
                cand_valid = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/snoop_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : snoop_arbiter                                                   |
// | Purpose  : Hands core buffers to the snooper round-robin, steers writes.   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module snoop_arbiter
    import snoop_arbiter_pkg::*;
#(
    parameter int N_CORES           = 4,
    parameter int SN_FWD_DATA_WIDTH = 64,
    parameter int SN_FWD_ADDR_WIDTH = 9,
    parameter int INC_WIDTH         = 8,
    parameter int LEN_WIDTH         = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [SN_FWD_ADDR_WIDTH-1:0] sn_addr,
    input  logic [SN_FWD_DATA_WIDTH-1:0] sn_wr_data,
    input  logic                         sn_wr_en,
    input  logic [INC_WIDTH-1:0]         sn_byte_inc,
    input  logic                         sn_done,
    output logic                         rdy_for_sn,
    input  logic                         rdy_for_sn_ack,
    input  logic [N_CORES-1:0]           core_rdy_for_sn,
    output logic [N_CORES-1:0]           core_rdy_for_sn_ack,
    output logic [SN_FWD_ADDR_WIDTH-1:0] core_addr,
    output logic [SN_FWD_DATA_WIDTH-1:0] core_wr_data,
    output logic [N_CORES-1:0]           core_wr_en,
    output logic [N_CORES-1:0]           core_done,
    output logic [LEN_WIDTH-1:0]         core_len
);

    localparam int SEL_WIDTH = clog2(N_CORES);

    arb_state_t           r_state;
    logic [SEL_WIDTH-1:0] r_sel;
    logic [SEL_WIDTH-1:0] r_rr_last;
    logic [LEN_WIDTH-1:0] r_len_acc;
    logic [N_CORES-1:0]   r_claim;
    logic [N_CORES-1:0]   r_done;
    logic [LEN_WIDTH-1:0] r_core_len;

    logic                 w_filling;
    logic [N_CORES-1:0]   w_sel_onehot;
    logic [N_CORES-1:0]   w_cand_onehot;
    logic [N_CORES-1:0]   w_exclude;
    logic [SEL_WIDTH-1:0] w_cand;
    logic                 w_cand_valid;
    logic [LEN_WIDTH:0]   w_sum;
    logic [LEN_WIDTH-1:0] w_len_next;

    assign w_filling     = (r_state == FILL);
    assign w_sel_onehot  = N_CORES'(1) << r_sel;
    assign w_cand_onehot = N_CORES'(1) << w_cand;
    assign w_exclude     = w_filling ? w_sel_onehot : '0;

    snoop_arbiter_rr_picker #(
        .N_CORES   (N_CORES),
        .SEL_WIDTH (SEL_WIDTH)
    ) u_rr_picker (
        .req        (core_rdy_for_sn),
        .rr_last    (r_rr_last),
        .exclude    (w_exclude),
        .cand       (w_cand),
        .cand_valid (w_cand_valid)
    );

    // One extra bit catches the carry out so the length clamps at all-ones.
    assign w_sum      = {1'b0, r_len_acc} + (LEN_WIDTH + 1)'(sn_byte_inc);
    assign w_len_next = !sn_wr_en      ? r_len_acc :
                        w_sum[LEN_WIDTH] ? '1       : w_sum[LEN_WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= EMPTY;
            r_sel      <= '0;
            r_rr_last  <= SEL_WIDTH'(N_CORES - 1);
            r_len_acc  <= '0;
            r_claim    <= '0;
            r_done     <= '0;
            r_core_len <= '0;
        end else begin
            r_claim    <= '0;
            r_done     <= '0;
            r_core_len <= '0;
            case (r_state)
                EMPTY: begin
                    if (w_cand_valid) begin
                        r_sel   <= w_cand;
                        r_state <= OFFER;
                    end
                end
                OFFER: begin
                    if (!core_rdy_for_sn[r_sel]) begin
                        r_state <= EMPTY;
                    end else if (rdy_for_sn_ack) begin
                        r_claim   <= w_sel_onehot;
                        r_rr_last <= r_sel;
                        r_len_acc <= '0;
                        r_state   <= FILL;
                    end
                end
                FILL: begin
                    r_len_acc <= w_len_next;
                    if (sn_done) begin
                        r_done     <= w_sel_onehot;
                        r_core_len <= w_len_next;
                        r_len_acc  <= '0;
                        // Re-offer in the TLAST cycle so back-to-back packets never stall.
                        if (w_cand_valid && rdy_for_sn_ack) begin
                            r_claim   <= w_cand_onehot;
                            r_sel     <= w_cand;
                            r_rr_last <= w_cand;
                        end else begin
                            r_state <= EMPTY;
                        end
                    end
                end
                default: r_state <= EMPTY;
            endcase
        end
    end

    assign rdy_for_sn          = (r_state == OFFER) || (w_filling && w_cand_valid);
    assign core_wr_en          = (w_filling && sn_wr_en) ? w_sel_onehot : '0;
    assign core_addr           = w_filling ? sn_addr    : '0;
    assign core_wr_data        = w_filling ? sn_wr_data : '0;
    assign core_rdy_for_sn_ack = r_claim;
    assign core_done           = r_done;
    assign core_len            = r_core_len;

endmodule
`default_nettype wire

// File: tb/tb_snoop_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_snoop_arbiter                                                |
// | Purpose  : Directed stimulus with a buffer-ownership reference model.      |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_snoop_arbiter;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [8:0]  sn_addr;
    logic [63:0] sn_wr_data;
    logic        sn_wr_en;
    logic [7:0]  sn_byte_inc;
    logic        sn_done;
    logic        rdy_for_sn;
    logic        rdy_for_sn_ack;
    logic [3:0]  core_rdy_for_sn;
    logic [3:0]  core_rdy_for_sn_ack;
    logic [8:0]  core_addr;
    logic [63:0] core_wr_data;
    logic [3:0]  core_wr_en;
    logic [3:0]  core_done;
    logic [15:0] core_len;

    int n_cmp = 0;
    int n_bad = 0;

    snoop_arbiter dut (
        .clk                 (clk),
        .rst                 (rst),
        .sn_addr             (sn_addr),
        .sn_wr_data          (sn_wr_data),
        .sn_wr_en            (sn_wr_en),
        .sn_byte_inc         (sn_byte_inc),
        .sn_done             (sn_done),
        .rdy_for_sn          (rdy_for_sn),
        .rdy_for_sn_ack      (rdy_for_sn_ack),
        .core_rdy_for_sn     (core_rdy_for_sn),
        .core_rdy_for_sn_ack (core_rdy_for_sn_ack),
        .core_addr           (core_addr),
        .core_wr_data        (core_wr_data),
        .core_wr_en          (core_wr_en),
        .core_done           (core_done),
        .core_len            (core_len)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] oh(input int i);
        return (i < 0) ? 4'b0000 : 4'(1 << i);
    endfunction

    // First ready buffer after `last`, skipping the buffer currently owned.
    function automatic int pick(input logic [3:0] req, input int last, input int owned);
        int i;
        for (int k = 1; k <= N; k++) begin
            i = (last + k) % N;
            if (req[i] && i != owned) return i;
        end
        return -1;
    endfunction

    // Reference model: which buffer is offered / owned, and pending pulses.
    int m_on       = 0;
    int m_offer    = -1;
    int m_owner    = -1;
    int m_last     = N - 1;
    int m_len      = 0;
    int m_claim    = -1;
    int m_done     = -1;
    int m_done_len = 0;

    always @(negedge clk) begin : p_model
        int cand;
        int nl;
        cand = pick(core_rdy_for_sn, m_last, m_owner);
        if (m_on != 0) begin
            chk("rdy_for_sn", 64'(rdy_for_sn), 64'((m_offer >= 0) || (m_owner >= 0 && cand >= 0)));
            chk("core_wr_en", 64'(core_wr_en), 64'((m_owner >= 0 && sn_wr_en) ? oh(m_owner) : 4'b0));
            chk("core_addr", 64'(core_addr), 64'((m_owner >= 0) ? sn_addr : 9'd0));
            chk("core_wr_data", core_wr_data, (m_owner >= 0) ? sn_wr_data : 64'd0);
            chk("claim", 64'(core_rdy_for_sn_ack), 64'(oh(m_claim)));
            chk("core_done", 64'(core_done), 64'(oh(m_done)));
            chk("core_len", 64'(core_len), 64'((m_done >= 0) ? m_done_len : 0));
        end
        m_claim = -1;
        m_done  = -1;
        if (rst) begin
            m_offer = -1;
            m_owner = -1;
            m_last  = N - 1;
            m_len   = 0;
            m_on    = 1;
        end else if (m_offer >= 0) begin
            if (!core_rdy_for_sn[m_offer]) begin
                m_offer = -1;
            end else if (rdy_for_sn_ack) begin
                m_claim = m_offer;
                m_owner = m_offer;
                m_last  = m_offer;
                m_offer = -1;
                m_len   = 0;
            end
        end else if (m_owner >= 0) begin
            nl = m_len + (sn_wr_en ? int'(sn_byte_inc) : 0);
            if (nl > 65535) nl = 65535;
            m_len = nl;
            if (sn_done) begin
                m_done     = m_owner;
                m_done_len = nl;
                m_len      = 0;
                if (cand >= 0 && rdy_for_sn_ack) begin
                    m_claim = cand;
                    m_owner = cand;
                    m_last  = cand;
                end else begin
                    m_owner = -1;
                end
            end
        end else if (cand >= 0) begin
            m_offer = cand;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic wr, input logic [7:0] inc, input logic done,
                         input logic ack, input int k);
        sn_wr_en       = wr;
        sn_byte_inc    = inc;
        sn_done        = done;
        rdy_for_sn_ack = ack;
        sn_addr        = 9'(k);
        sn_wr_data     = 64'hC0DE_0000_0000_0000 | 64'(k * 64'h1_0001);
    endtask

    // Advances until a claim pulse shows up; a missing claim is a failed check.
    task automatic wait_claim(input logic [3:0] exp, input string nm);
        int n;
        n = 0;
        tick();
        @(negedge clk);
        while (core_rdy_for_sn_ack == 4'b0000 && n < 8) begin
            tick();
            @(negedge clk);
            n++;
        end
        chk(nm, 64'(core_rdy_for_sn_ack), 64'(exp));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    logic [3:0] exp_claims [5];

    initial begin
        exp_claims = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
        rst             = 1'b1;
        core_rdy_for_sn = 4'b0000;
        drive(1'b0, 8'd0, 1'b0, 1'b0, 0);
        repeat (3) tick();

        // Reset state, then offer core 0 with ack held.
        rst             = 1'b0;
        core_rdy_for_sn = 4'b0001;
        drive(1'b0, 8'd0, 1'b0, 1'b1, 0);
        @(negedge clk);
        chk("reset_rdy", 64'(rdy_for_sn), 64'd0);
        chk("reset_claim", 64'(core_rdy_for_sn_ack), 64'd0);
        tick();
        @(negedge clk);
        chk("offer_rdy", 64'(rdy_for_sn), 64'd1);
        tick();

        // Four 8-byte writes on core 0, last one with done.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 8'd8, (i == 3), 1'b0, i);
            @(negedge clk);
            if (i == 0) chk("first_claim", 64'(core_rdy_for_sn_ack), 64'h1);
            chk("pkt0_wr_en", 64'(core_wr_en), 64'h1);
            tick();
        end
        core_rdy_for_sn = 4'b1111;
        drive(1'b0, 8'd0, 1'b0, 1'b1, 0);
        @(negedge clk);
        chk("pkt0_done", 64'(core_done), 64'h1);
        chk("pkt0_len", 64'(core_len), 64'd32);
        tick();
        tick();

        // Five back-to-back 12-byte packets across all four cores.
        for (int p = 0; p < 5; p++) begin
            drive(1'b1, 8'd5, 1'b0, 1'b1, 2 * p);
            @(negedge clk);
            chk("b2b_claim", 64'(core_rdy_for_sn_ack), 64'(exp_claims[p]));
            chk("b2b_rdy", 64'(rdy_for_sn), 64'd1);
            if (p > 0) chk("b2b_len", 64'(core_len), 64'd12);
            tick();
            drive(1'b1, 8'd7, 1'b1, (p < 4), 2 * p + 1);
            @(negedge clk);
            chk("b2b_rdy_last", 64'(rdy_for_sn), 64'd1);
            tick();
        end

        // Only core 0 free: no lookahead offer while it is owned.
        core_rdy_for_sn = 4'b0001;
        drive(1'b0, 8'd0, 1'b0, 1'b1, 0);
        @(negedge clk);
        chk("b2b_last_done", 64'(core_done), 64'b0010);
        wait_claim(4'b0001, "solo_claim");
        tick();
        drive(1'b1, 8'd4, 1'b1, 1'b1, 7);
        @(negedge clk);
        chk("solo_rdy_on_done", 64'(rdy_for_sn), 64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            core_rdy_for_sn = 4'b0000;
            drive(1'b1, 8'd4, 1'b1, 1'b1, 20 + i);
            @(negedge clk);
            chk("idle_wr_en", 64'(core_wr_en), 64'd0);
            chk("idle_done", 64'(core_done), (i == 0) ? 64'h1 : 64'h0);
            if (i == 0) chk("solo_len", 64'(core_len), 64'd4);
        end

        // Offer core 2, withdraw readiness before ack, then offer again.
        tick();
        core_rdy_for_sn = 4'b0100;
        drive(1'b0, 8'd0, 1'b0, 1'b0, 0);
        tick();
        core_rdy_for_sn = 4'b0000;
        drive(1'b0, 8'd0, 1'b0, 1'b1, 0);
        @(negedge clk);
        chk("withdraw_rdy", 64'(rdy_for_sn), 64'd1);
        tick();
        core_rdy_for_sn = 4'b0100;
        @(negedge clk);
        chk("withdraw_claim", 64'(core_rdy_for_sn_ack), 64'd0);
        chk("withdraw_rdy_low", 64'(rdy_for_sn), 64'd0);
        wait_claim(4'b0100, "reoffer_claim");

        // Reset in the middle of a packet on core 2.
        tick();
        drive(1'b1, 8'd9, 1'b0, 1'b0, 30);
        tick();
        drive(1'b1, 8'd9, 1'b0, 1'b0, 31);
        tick();
        rst = 1'b1;
        drive(1'b0, 8'd0, 1'b0, 1'b0, 0);
        tick();
        rst             = 1'b0;
        core_rdy_for_sn = 4'b1111;
        drive(1'b0, 8'd0, 1'b0, 1'b1, 0);
        @(negedge clk);
        chk("rst_rdy", 64'(rdy_for_sn), 64'd0);
        chk("rst_done", 64'(core_done), 64'd0);
        chk("rst_wr_en", 64'(core_wr_en), 64'd0);
        chk("rst_len", 64'(core_len), 64'd0);
        wait_claim(4'b0001, "post_rst_claim");
        tick();
        drive(1'b1, 8'd3, 1'b1, 1'b1, 40);
        tick();

        // Length saturates at 16'hFFFF (260 * 255 overflows).
        for (int i = 0; i < 260; i++) begin
            drive(1'b1, 8'd255, (i == 259), 1'b0, i);
            @(negedge clk);
            if (i == 0) begin
                chk("post_rst_len", 64'(core_len), 64'd3);
                chk("post_rst_done", 64'(core_done), 64'h1);
                chk("post_rst_claim2", 64'(core_rdy_for_sn_ack), 64'b0010);
            end
            tick();
        end
        drive(1'b0, 8'd0, 1'b0, 1'b0, 0);
        @(negedge clk);
        chk("sat_done", 64'(core_done), 64'b0010);
        chk("sat_len", 64'(core_len), 64'hFFFF);
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
